// File: rtl/lwg_pkg.sv
// Shared constants and helpers for the line window generator.
// Width helpers, packed-window element offsets, and legal parameter limits.
package lwg_pkg;

  localparam int KERNEL_MIN = 2;
  localparam int KERNEL_MAX = 7;
  localparam int STRIDE_MIN = 1;

  // Index width for a counter that spans 0..n-1 (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of window element (i, j); i=0 is the oldest row, j=0 the oldest column.
  function automatic int elem_lsb(input int i, input int j, input int k, input int bd);
    return (i * k + j) * bd;
  endfunction

endpackage

// File: rtl/lwg_line_delay.sv
// One image line of pixel delay: dout_o is the pixel written DEPTH enables ago.
// Implemented as a circular buffer so it maps onto RAM or a shift register.
module lwg_line_delay
  import lwg_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int DEPTH     = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [BIT_DEPTH-1:0] din_i,
  output logic [BIT_DEPTH-1:0] dout_o
);

  localparam int PTR_W = idx_w(DEPTH);

  logic [BIT_DEPTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_d;

  // Slot under the pointer still holds the oldest pixel until it is overwritten.
  assign dout_o = mem_q[ptr_q];

  // Next write position wraps at the line length.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pixel storage is never reset; downstream valid gating hides stale data.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  // Write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Raster-stream KERNEL x KERNEL sliding-window generator with stride.
// Optional macro LWG_STALL_CNT_EN adds a saturating output-stall counter port.
module line_window_gen
  import lwg_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int KERNEL    = 3,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int STRIDE    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BIT_DEPTH-1:0]                in_data,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic [KERNEL*KERNEL*BIT_DEPTH-1:0]  win_data,
  output logic [idx_w(IMG_H)-1:0]             win_row,
  output logic [idx_w(IMG_W)-1:0]             win_col,
  output logic                                frame_done
`ifdef LWG_STALL_CNT_EN
  ,output logic [31:0]                        stall_cnt
`endif
);

  localparam int ROW_W = idx_w(IMG_H);
  localparam int COL_W = idx_w(IMG_W);
  localparam int PH_W  = idx_w(STRIDE);
  localparam int WIN_W = KERNEL * KERNEL * BIT_DEPTH;

  if (KERNEL < KERNEL_MIN || KERNEL > KERNEL_MAX || STRIDE < STRIDE_MIN ||
      STRIDE > KERNEL || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_param_err
    $error("line_window_gen: illegal parameter combination");
  end

  logic                 accept;
  logic                 emit;
  logic                 col_last, row_last, col_ok, row_ok;

  logic [COL_W-1:0]     col_q, col_d, wcol_q, wcol_d;
  logic [ROW_W-1:0]     row_q, row_d, wrow_q, wrow_d;
  logic [PH_W-1:0]      col_ph_q, col_ph_d, row_ph_q, row_ph_d;

  logic                 win_valid_q;
  logic [WIN_W-1:0]     win_data_q;
  logic [ROW_W-1:0]     win_row_q;
  logic [COL_W-1:0]     win_col_q;
  logic                 frame_done_q;

  logic [KERNEL-2:0][BIT_DEPTH-1:0] tap;
  logic [BIT_DEPTH-1:0] win_q [KERNEL][KERNEL];
  logic [BIT_DEPTH-1:0] win_d [KERNEL][KERNEL];
  logic [WIN_W-1:0]     win_pack;

  assign in_ready   = !win_valid_q || win_ready;
  assign accept     = in_valid && in_ready;
  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

  // Chained line delays: tap[j] is the pixel from j+1 lines above the input.
  for (genvar g = 0; g < KERNEL - 1; g++) begin : g_line
    logic [BIT_DEPTH-1:0] din;
    if (g == 0) begin : g_head
      assign din = in_data;
    end else begin : g_chain
      assign din = tap[g-1];
    end
    lwg_line_delay #(
      .BIT_DEPTH (BIT_DEPTH),
      .DEPTH     (IMG_W)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .en_i   (accept),
      .din_i  (din),
      .dout_o (tap[g])
    );
  end

  // Window after this accept: shift left one column, new column on the right.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    for (int i = 0; i < KERNEL - 1; i++) begin
      win_d[i][KERNEL-1] = tap[KERNEL-2-i];
    end
    win_d[KERNEL-1][KERNEL-1] = in_data;
  end

  // Flatten the post-shift window into the output packing order.
  always_comb begin
    win_pack = '0;
    for (int i = 0; i < KERNEL; i++) begin
      for (int j = 0; j < KERNEL; j++) begin
        win_pack[elem_lsb(i, j, KERNEL, BIT_DEPTH) +: BIT_DEPTH] = win_d[i][j];
      end
    end
  end

  // Window shift register advances only on accepted pixels.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  // Legal window positions: past the first KERNEL-1 lines/columns and on a stride phase.
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign col_ok   = (col_q >= COL_W'(KERNEL - 1)) && (col_ph_q == '0);
  assign row_ok   = (row_q >= ROW_W'(KERNEL - 1)) && (row_ph_q == '0);
  assign emit     = accept && col_ok && row_ok;

  // Raster position, stride phases and output indices for the next pixel.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    wcol_d   = wcol_q;
    wrow_d   = wrow_q;
    if (accept) begin
      if (col_last) begin
        col_d    = '0;
        col_ph_d = '0;
        wcol_d   = '0;
        if (row_last) begin
          row_d    = '0;
          row_ph_d = '0;
          wrow_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
          if (row_ok) begin
            wrow_d = wrow_q + ROW_W'(1);
          end
          if (row_q >= ROW_W'(KERNEL - 1)) begin
            row_ph_d = (row_ph_q == PH_W'(STRIDE - 1)) ? '0 : row_ph_q + PH_W'(1);
          end
        end
      end else begin
        col_d = col_q + COL_W'(1);
        if (col_ok) begin
          wcol_d = wcol_q + COL_W'(1);
        end
        if (col_q >= COL_W'(KERNEL - 1)) begin
          col_ph_d = (col_ph_q == PH_W'(STRIDE - 1)) ? '0 : col_ph_q + PH_W'(1);
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
      wcol_q   <= '0;
      wrow_q   <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      wcol_q   <= wcol_d;
      wrow_q   <= wrow_d;
    end
  end

  // Single output register: loads on emit, otherwise clears once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && col_last && row_last;
      if (emit) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_pack;
        win_row_q   <= wrow_q;
        win_col_q   <= wcol_q;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef LWG_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Cycles a window waited on downstream, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (win_valid_q && !win_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_window_gen.sv
// Self-checking bench for line_window_gen (5x5 image, 3x3 kernel, strides 1 and 2).
module tb_line_window_gen;

  localparam int BD = 8;
  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = K * K * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          win_ready = 1'b0;
  logic [BD-1:0] in_data = '0;

  logic          rdy1, rdy2, wv1, wv2, fd1, fd2;
  logic [DW-1:0] wd1, wd2;
  logic [2:0]    wr1, wr2, wc1, wc2;
`ifdef LWG_STALL_CNT_EN
  logic [31:0]   sc1, sc2;
`endif

  always #5 clk = ~clk;

  line_window_gen #(.BIT_DEPTH(BD), .KERNEL(K), .IMG_W(W), .IMG_H(H), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .win_valid(wv1), .win_ready(win_ready), .win_data(wd1), .win_row(wr1), .win_col(wc1),
    .frame_done(fd1)
`ifdef LWG_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  line_window_gen #(.BIT_DEPTH(BD), .KERNEL(K), .IMG_W(W), .IMG_H(H), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .win_valid(wv2), .win_ready(win_ready), .win_data(wd2), .win_row(wr2), .win_col(wc2),
    .frame_done(fd2)
`ifdef LWG_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );

  // Which instance is under observation.
  bit            sel = 1'b0;
  logic          o_rdy, o_v, o_fd;
  logic [DW-1:0] o_data;
  logic [2:0]    o_row, o_col;
  assign o_rdy  = sel ? rdy2 : rdy1;
  assign o_v    = sel ? wv2  : wv1;
  assign o_fd   = sel ? fd2  : fd1;
  assign o_data = sel ? wd2  : wd1;
  assign o_row  = sel ? wr2  : wr1;
  assign o_col  = sel ? wc2  : wc1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the frame as a 2-D array, windows cut from it directly.
  typedef struct {
    int            row;
    int            col;
    logic [DW-1:0] data;
  } win_t;

  win_t          exp_q[$];
  logic [BD-1:0] img [H][W];
  int            mr, mc, mstride;
  bit            fd_exp, stalled_prev;
  logic [DW-1:0] prev_data, first_win, last_win;
  int            nwin, nfd;

  task automatic model_reset();
    mr = 0;
    mc = 0;
    exp_q.delete();
    fd_exp = 1'b0;
    stalled_prev = 1'b0;
    nwin = 0;
    nfd = 0;
  endtask

  task automatic model_accept(input logic [BD-1:0] d);
    win_t w;
    img[mr][mc] = d;
    if (mr >= K - 1 && mc >= K - 1 && (mr - K + 1) % mstride == 0 && (mc - K + 1) % mstride == 0) begin
      w.row = (mr - K + 1) / mstride;
      w.col = (mc - K + 1) / mstride;
      w.data = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w.data[(i * K + j) * BD +: BD] = img[mr - K + 1 + i][mc - K + 1 + j];
      exp_q.push_back(w);
    end
    if (mc == W - 1) begin
      mc = 0;
      if (mr == H - 1) begin
        mr = 0;
        fd_exp = 1'b1;
      end else begin
        mr++;
      end
    end else begin
      mc++;
    end
  endtask

  // One clock: drive at negedge, sample just after, then advance the model.
  task automatic cycle(input bit v, input logic [BD-1:0] d, input bit rdy, output bit acc);
    win_t w;
    bit   take;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    win_ready = rdy;
    #1;
    chk("in_ready", o_rdy, !(o_v && !rdy));
    chk("win_valid", o_v, exp_q.size() != 0);
    chk("frame_done", o_fd, fd_exp);
    if (o_fd) nfd++;
    fd_exp = 1'b0;
    if (stalled_prev) chk("stall_hold", o_data, prev_data);
    take = o_v && rdy;
    acc  = v && o_rdy;
    if (take) begin
      nwin++;
      if (nwin == 1) first_win = o_data;
      last_win = o_data;
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("win_data", o_data, w.data);
        chk("win_row", o_row, w.row);
        chk("win_col", o_col, w.col);
      end
    end
    if (acc) model_accept(d);
    stalled_prev = o_v && !rdy;
    prev_data = o_data;
  endtask

  task automatic stream(input int npix, input bit rnd_v, input bit rnd_r, input bit rnd_d);
    int            sent;
    int            cyc;
    bit            acc;
    logic [BD-1:0] cur;
    sent = 0;
    cyc = 0;
    cur = rnd_d ? BD'($urandom) : BD'(100 * (sent / 25) + sent % 25 + 1);
    while (sent < npix && cyc < 2000) begin
      cycle(rnd_v ? 1'($urandom) : 1'b1, cur, rnd_r ? 1'($urandom) : 1'b1, acc);
      cyc++;
      if (acc) begin
        sent++;
        cur = rnd_d ? BD'($urandom) : BD'(100 * (sent / 25) + sent % 25 + 1);
      end
    end
    chk("stream_done", sent, npix);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, '0, 1'b1, acc);
    chk("drain_empty", exp_q.size(), 0);
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    win_ready = 1'b1;
    #1;
    chk("rst_valid", o_v, 1'b0);
    chk("rst_frame_done", o_fd, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_data", o_data, '0);
    chk("rst_row", o_row, 0);
    chk("rst_col", o_col, 0);
    rst = 1'b0;
    model_reset();
  endtask

  logic [DW-1:0] exp_first, exp_last;
  int            first_px[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
  int            last_px[9]  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 9; k++) begin
      exp_first[k * BD +: BD] = BD'(first_px[k]);
      exp_last[k * BD +: BD]  = BD'(last_px[k]);
    end
    mstride = 1;
    model_reset();

    #2 rst = 1'b1;
    #1;
    chk("init_valid", wv1, 1'b0);
    chk("init_data", wd1, '0);
    chk("init_frame_done", fd1, 1'b0);
    do_reset();

    // Full-rate single frame.
    stream(25, 1'b0, 1'b0, 1'b0);
    drain();
    chk("s1_count", nwin, 9);
    chk("s1_first", first_win, exp_first);
    chk("s1_last", last_win, exp_last);
    chk("s1_frame_done", nfd, 1);

    // Stride 2 instance.
    sel = 1'b1;
    mstride = 2;
    do_reset();
    stream(25, 1'b0, 1'b0, 1'b0);
    drain();
    chk("s2_count", nwin, 4);
    chk("s2_centre", last_win[4 * BD +: BD], 19);
    sel = 1'b0;
    mstride = 1;
    do_reset();

    // Random downstream backpressure, input always valid.
    stream(25, 1'b0, 1'b1, 1'b0);
    drain();
    chk("bp_count", nwin, 9);
    chk("bp_first", first_win, exp_first);
    chk("bp_last", last_win, exp_last);

    // Two back-to-back frames with no gap.
    do_reset();
    stream(50, 1'b0, 1'b0, 1'b0);
    drain();
    chk("b2b_count", nwin, 18);
    chk("b2b_frame_done", nfd, 2);

    // Random valid, ready and pixel values over two frames.
    do_reset();
    stream(50, 1'b1, 1'b1, 1'b1);
    drain();
    chk("rnd_count", nwin, 18);
    chk("rnd_frame_done", nfd, 2);

    // Reset after 12 pixels, then a clean frame.
    do_reset();
    stream(12, 1'b0, 1'b0, 1'b0);
    chk("mid_none", nwin, 0);
    do_reset();
    stream(25, 1'b0, 1'b0, 1'b0);
    drain();
    chk("mid_count", nwin, 9);
    chk("mid_first", first_win, exp_first);

`ifdef LWG_STALL_CNT_EN
    do_reset();
    stream(13, 1'b0, 1'b0, 1'b0);
    begin
      bit acc;
      for (int k = 0; k < 7; k++) cycle(1'b0, '0, 1'b0, acc);
    end
    @(negedge clk);
    #1;
    chk("stall_cnt", sc1, 7);
    do_reset();
    chk("stall_cnt_rst", sc1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
